// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the memory port, fetches 1/2-byte instructions, hands them off via valid/ready.
// Optional: define FETCH_STALL_CNT_EN to add a saturating stall_cnt output.
module fetch_unit #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 8,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              dmem_req,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    input  logic              fetch_en,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_op,
    output logic [DATA_W-1:0] inst_arg,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_OP  = 2'd0,
        ST_ARG = 2'd1,
        ST_VAL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] arg_q, arg_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;

    // Data accesses always win the shared port; fetch simply waits.
    assign mem_addr   = dmem_req ? dmem_addr : pc_q;
    assign mem_we     = dmem_req & dmem_we;
    assign mem_wdata  = dmem_wdata;
    assign dmem_rdata = mem_rdata;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        arg_d   = arg_q;
        ipc_d   = ipc_q;

        case (state_q)
            ST_OP: begin
                if (fetch_en && !dmem_req) begin
                    op_d  = mem_rdata;
                    ipc_d = pc_q;
                    pc_d  = pc_q + ADDR_W'(1);
                    if (mem_rdata[DATA_W-1]) begin
                        state_d = ST_ARG;
                    end else begin
                        arg_d   = '0;
                        state_d = ST_VAL;
                    end
                end
            end
            ST_ARG: begin
                if (!dmem_req) begin
                    arg_d   = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_VAL;
                end
            end
            ST_VAL: begin
                if (inst_ready) state_d = ST_OP;
            end
            default: state_d = ST_OP;
        endcase

        // A redirect cancels whatever this cycle's fetch would have captured.
        if (br_valid) begin
            state_d = ST_OP;
            pc_d    = br_target;
            op_d    = op_q;
            arg_d   = arg_q;
            ipc_d   = ipc_q;
        end
    end

    assign valid_d = (state_d == ST_VAL);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
        if (!rst_n) begin
            state_q <= ST_OP;
            pc_q    <= RESET_VEC;
            op_q    <= '0;
            arg_q   <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign inst_valid = valid_q;
    assign inst_op    = op_q;
    assign inst_arg   = arg_q;
    assign inst_pc    = ipc_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        stalled;

    assign stalled = ((state_q == ST_OP) && (dmem_req || !fetch_en)) ||
                     ((state_q == ST_ARG) && dmem_req);
    assign stall_d = (stalled && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic against a byte-stream model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic       mem_we, dmem_req, dmem_we, fetch_en, br_valid, inst_valid, inst_ready;
    logic [7:0] br_target, inst_op, inst_arg, inst_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_VEC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .fetch_en(fetch_en), .br_valid(br_valid), .br_target(br_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_op(inst_op), .inst_arg(inst_arg), .inst_pc(inst_pc)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction is a run of bytes read from successive PCs;
    // its length comes from the opcode's top bit, and it is held until accepted.
    logic [7:0]  m_pc, m_op, m_arg, m_ipc;
    int          m_have, m_len;
    bit          m_valid;
    int unsigned m_stall;

    task automatic model_reset();
        m_pc = 8'h00; m_op = 0; m_arg = 0; m_ipc = 0;
        m_have = 0; m_len = 1; m_valid = 0; m_stall = 0;
    endtask

    task automatic model_step();
        bit   can_take;
        logic [7:0] b;
        if (!rst_n) begin
            model_reset();
            return;
        end
        can_take = !m_valid && !dmem_req && (m_have > 0 || fetch_en);
        if (!m_valid && !can_take && m_stall < 16'hFFFF) m_stall++;
        if (br_valid) begin
            m_pc = br_target; m_have = 0; m_valid = 0;
        end else if (m_valid) begin
            if (inst_ready) begin m_valid = 0; m_have = 0; end
        end else if (can_take) begin
            b = mem[m_pc];
            if (m_have == 0) begin
                m_op = b; m_ipc = m_pc; m_arg = 0; m_len = b[7] ? 2 : 1;
            end else begin
                m_arg = b;
            end
            m_have++;
            m_pc = m_pc + 8'd1;
            if (m_have == m_len) m_valid = 1;
        end
    endtask

    task automatic step(input logic rst, input logic fen, input logic rdy, input logic br,
                        input logic [7:0] tgt, input logic dreq, input logic dwe,
                        input logic [7:0] da, input logic [7:0] dw);
        logic [7:0] exp_addr;
        @(negedge clk);
        rst_n = rst; fetch_en = fen; inst_ready = rdy; br_valid = br; br_target = tgt;
        dmem_req = dreq; dmem_we = dwe; dmem_addr = da; dmem_wdata = dw;
        #1;
        exp_addr = dreq ? da : m_pc;
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", mem_we, dreq & dwe);
        check("mem_wdata", mem_wdata, dw);
        check("dmem_rdata", dmem_rdata, mem[exp_addr]);
        check("inst_valid", inst_valid, m_valid);
        if (m_valid) begin
            check("inst_op", inst_op, m_op);
            check("inst_arg", inst_arg, m_arg);
            check("inst_pc", inst_pc, m_ipc);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic fen, input logic rdy);
        step(1, fen, rdy, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    logic [7:0] hold_op, hold_arg, hold_pc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst_n = 0; fetch_en = 0; inst_ready = 0; br_valid = 0; br_target = 0;
        dmem_req = 0; dmem_we = 0; dmem_addr = 0; dmem_wdata = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset, then a 1-byte instruction at 0.
        mem[0] = 8'h12;
        step(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        check("rst_valid", inst_valid, 0);
        check("rst_op", inst_op, 0);
        check("rst_arg", inst_arg, 0);
        check("rst_pc", inst_pc, 0);
        run(1, 0);
        check("t1_valid", inst_valid, 1);
        check("t1_op", inst_op, 8'h12);
        check("t1_arg", inst_arg, 8'h00);
        check("t1_pc", inst_pc, 8'h00);
        check("t1_next_pc", mem_addr, 8'h01);

        // Redirect while consuming, then a 2-byte instruction at 4.
        mem[4] = 8'h85; mem[5] = 8'h3C;
        step(1, 1, 1, 1, 8'h04, 0, 0, 8'h00, 8'h00);
        check("t2_valid_after_br", inst_valid, 0);
        run(1, 0);
        check("t2_not_yet", inst_valid, 0);
        run(1, 0);
        check("t2_op", inst_op, 8'h85);
        check("t2_arg", inst_arg, 8'h3C);
        check("t2_pc", inst_pc, 8'h04);
        check("t2_next_pc", mem_addr, 8'h06);

        // Data write in ARG holds fetch for one cycle.
        mem[6] = 8'h90; mem[7] = 8'h5A; mem[8'h40] = 8'h00;
        run(1, 1);
        run(1, 0);
        step(1, 1, 0, 0, 8'h00, 1, 1, 8'h40, 8'hAA);
        check("t3_held", inst_valid, 0);
        check("t3_written", mem[8'h40], 8'hAA);
        run(1, 0);
        check("t3_valid", inst_valid, 1);
        check("t3_arg", inst_arg, 8'h5A);

        // 2-byte opcode at 0xFF wraps for its operand.
        mem[8'hFF] = 8'hC1; mem[0] = 8'h77;
        step(1, 1, 1, 1, 8'hFF, 0, 0, 8'h00, 8'h00);
        run(1, 0);
        run(1, 0);
        check("t4_arg", inst_arg, 8'h77);
        check("t4_pc", inst_pc, 8'hFF);
        check("t4_wrap_pc", mem_addr, 8'h01);

        // Backpressure keeps the instruction stable.
        hold_op = inst_op; hold_arg = inst_arg; hold_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            run(1, 0);
            check("t5_valid", inst_valid, 1);
            check("t5_op", inst_op, hold_op);
            check("t5_arg", inst_arg, hold_arg);
            check("t5_pc", inst_pc, hold_pc);
        end
        // Redirect in ARG discards the partial fetch.
        mem[1] = 8'h81;
        run(1, 1);
        run(1, 0);
        step(1, 1, 0, 1, 8'h20, 0, 0, 8'h00, 8'h00);
        check("t5_br_valid", inst_valid, 0);
        check("t5_br_pc", mem_addr, 8'h20);

        // Reset mid-ARG, then stalls in OP from data reads.
        mem[8'h20] = 8'h88;
        run(1, 0);
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        check("t6_valid", inst_valid, 0);
        check("t6_pc", mem_addr, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'h00, 1, 0, 8'h10, 8'h00);
`ifdef FETCH_STALL_CNT_EN
        check("t6_stall", stall_cnt, 16'd3);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom),
                 8'($urandom),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
